// File: rtl/mob_pkg.sv
`default_nettype none
// ============================================================================
// Module : mob_pkg
// Brief  : Shared types and constants for the scanline motion-object engine.
// Rev    : 1.0  initial release
// ============================================================================
package mob_pkg;

   localparam int MOB_TILE = 8;

   localparam logic [1:0] REG_PIC  = 2'd0;
   localparam logic [1:0] REG_VERT = 2'd1;
   localparam logic [1:0] REG_HORZ = 2'd2;
   localparam logic [1:0] REG_ATTR = 2'd3;

   typedef struct packed {
      logic       hide;
      logic [3:0] reserved;
      logic       vflip;
      logic       hflip;
      logic       wide;
   } mob_attr_t;

   typedef struct packed {
      logic [7:0] picture;
      logic [7:0] vert;
      logic [7:0] horz;
      mob_attr_t  attr;
   } mob_entry_t;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_SCAN = 1'b1
   } mob_state_t;

   function automatic logic [8:0] mob_height(input logic wide);
      return wide ? 9'(2 * MOB_TILE) : 9'(MOB_TILE);
   endfunction

endpackage
`default_nettype wire

// File: rtl/mob_line_engine_if.sv
`default_nettype none
// ============================================================================
// Module : mob_line_engine_if
// Brief  : 6502 MMIO bus between the CPU side (master) and the engine (slave).
// Rev    : 1.0  initial release
// ============================================================================
interface mob_line_engine_if;
   logic [15:0] addr;
   logic [7:0]  data_in;
   logic        we_l;
   logic [7:0]  data_out;

   modport master (output addr, output data_in, output we_l, input data_out);
   modport slave  (input addr, input data_in, input we_l, output data_out);
endinterface
`default_nettype wire

// File: rtl/mob_slot_match.sv
`default_nettype none
// ============================================================================
// Module : mob_slot_match
// Brief  : Per-slot horizontal hit test and in-tile row/column generation.
// Rev    : 1.0  initial release
// ============================================================================
module mob_slot_match (
   input  wire logic       i_valid,
   input  wire logic [7:0] i_col,
   input  wire logic [7:0] i_check_row,
   input  wire logic [7:0] i_horz,
   input  wire logic [7:0] i_vert,
   input  wire logic       i_wide,
   input  wire logic       i_hflip,
   input  wire logic       i_vflip,
   output logic            o_hit,
   output logic            o_wide,
   output logic [2:0]      o_col,
   output logic [2:0]      o_row
);
   logic [8:0] w_horz_end;
   logic [3:0] w_vofs;
   logic [3:0] w_vofs_f;

   // 9-bit end point so objects near column 255 clip instead of wrapping
   assign w_horz_end = {1'b0, i_horz} + 9'd8;
   assign o_hit      = i_valid && ({1'b0, i_col} >= {1'b0, i_horz})
                               && ({1'b0, i_col} < w_horz_end);

   assign w_vofs   = 4'(i_vert) - 4'(i_check_row);
   assign w_vofs_f = i_vflip ? ((i_wide ? 4'd15 : 4'd7) - w_vofs) : w_vofs;
   assign o_row    = w_vofs_f[2:0];
   assign o_wide   = i_wide & w_vofs_f[3];
   assign o_col    = (3'(i_col) - 3'(i_horz)) ^ {3{i_hflip}};
endmodule
`default_nettype wire

// File: rtl/mob_line_engine.sv
`default_nettype none
// ============================================================================
// Module : mob_line_engine
// Brief  : Per-scanline motion-object evaluator with double-buffered MMIO regs.
//          Optional collision flags enabled by defining MOB_COLLIDE_EN.
// Rev    : 1.0  initial release
// ============================================================================
module mob_line_engine
   import mob_pkg::*;
#(
   parameter int          NUM_MOB    = 16,
   parameter int          SLOTS      = 8,
   parameter logic [15:0] BASE_ADDR  = 16'h07C0,
   parameter logic [7:0]  SCREEN_TOP = 8'd239
) (
   input  wire logic        clk,
   input  wire logic        rst,
   input  wire logic [7:0]  row,
   input  wire logic [7:0]  col,
   input  wire logic        line_start,
   input  wire logic        vblank,
   mob_line_engine_if.slave bus,
   output logic             motionSel,
   output logic             motionWide,
   output logic [7:0]       spriteID,
   output logic [2:0]       mob_row,
   output logic [2:0]       mob_col,
   output logic             overflow
);
   localparam int IDX_W = (NUM_MOB > 1) ? $clog2(NUM_MOB) : 1;
   localparam int CNT_W = $clog2(SLOTS + 1);

   mob_entry_t       r_shadow [NUM_MOB];
   mob_entry_t       r_active [NUM_MOB];
   logic             r_vblank_d;
   logic             r_copy_pend;
   mob_state_t       r_state;
   logic [IDX_W-1:0] r_idx;
   logic [CNT_W-1:0] r_cnt;
   logic [IDX_W-1:0] r_bld_idx [SLOTS];
   logic [IDX_W-1:0] r_dsp_idx [SLOTS];
   logic [SLOTS-1:0] r_dsp_vld;

   logic             w_vb_rise;
   logic             w_wr;
   logic [7:0]       w_check_row;
   mob_entry_t       w_scan_ent;
   logic             w_scan_hit;
   logic             w_ovf_set;
   logic             w_collide_bit;
   logic [SLOTS-1:0] w_hit;
   logic [SLOTS-1:0] w_wide;
   logic [2:0]       w_col [SLOTS];
   logic [2:0]       w_row [SLOTS];

   assign w_vb_rise   = vblank & ~r_vblank_d;
   assign w_check_row = SCREEN_TOP - row;
   assign w_wr        = ~bus.we_l && (bus.addr[15:6] == BASE_ADDR[15:6])
                        && ({1'b0, bus.addr[3:0]} < 5'(NUM_MOB));

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_MOB; i++) r_shadow[i] <= '0;
      end else if (w_wr) begin
         case (bus.addr[5:4])
            REG_PIC:  r_shadow[bus.addr[IDX_W-1:0]].picture <= bus.data_in;
            REG_VERT: r_shadow[bus.addr[IDX_W-1:0]].vert    <= bus.data_in;
            REG_HORZ: r_shadow[bus.addr[IDX_W-1:0]].horz    <= bus.data_in;
            default:  r_shadow[bus.addr[IDX_W-1:0]].attr    <= mob_attr_t'(bus.data_in);
         endcase
      end
   end

   // Copy lands one cycle after the vblank edge; same-cycle writes wait a frame
   always_ff @(posedge clk) begin
      if (rst) begin
         r_vblank_d  <= 1'b0;
         r_copy_pend <= 1'b0;
         for (int i = 0; i < NUM_MOB; i++) r_active[i] <= '0;
      end else begin
         r_vblank_d  <= vblank;
         r_copy_pend <= w_vb_rise;
         if (r_copy_pend) r_active <= r_shadow;
      end
   end

   assign w_scan_ent = r_active[r_idx];
   assign w_scan_hit = ~w_scan_ent.attr.hide
                       && ({1'b0, w_check_row} <= {1'b0, w_scan_ent.vert})
                       && (({1'b0, w_check_row} + mob_height(w_scan_ent.attr.wide))
                           > {1'b0, w_scan_ent.vert});
   assign w_ovf_set  = (r_state == ST_SCAN) && ~line_start && w_scan_hit
                       && (r_cnt == CNT_W'(SLOTS));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_idx     <= '0;
         r_cnt     <= '0;
         r_dsp_vld <= '0;
         for (int s = 0; s < SLOTS; s++) begin
            r_bld_idx[s] <= '0;
            r_dsp_idx[s] <= '0;
         end
      end else if (line_start) begin
         r_state <= ST_SCAN;
         r_idx   <= '0;
         r_cnt   <= '0;
         for (int s = 0; s < SLOTS; s++) r_bld_idx[s] <= '0;
      end else if (r_state == ST_SCAN) begin
         if (w_scan_hit && (r_cnt < CNT_W'(SLOTS))) begin
            for (int s = 0; s < SLOTS; s++)
               if (CNT_W'(s) == r_cnt) r_bld_idx[s] <= r_idx;
            r_cnt <= r_cnt + 1'b1;
         end
         if (r_idx == IDX_W'(NUM_MOB - 1)) begin
            // Publish the list including the hit evaluated this cycle
            for (int s = 0; s < SLOTS; s++) begin
               r_dsp_vld[s] <= (CNT_W'(s) < r_cnt) || (w_scan_hit && (CNT_W'(s) == r_cnt));
               r_dsp_idx[s] <= (w_scan_hit && (CNT_W'(s) == r_cnt)) ? r_idx : r_bld_idx[s];
            end
            r_state <= ST_IDLE;
         end else begin
            r_idx <= r_idx + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst || w_vb_rise) overflow <= 1'b0;
      else if (w_ovf_set)   overflow <= 1'b1;
   end

   for (genvar s = 0; s < SLOTS; s++) begin : g_slot
      mob_slot_match u_match (
         .i_valid     (r_dsp_vld[s]),
         .i_col       (col),
         .i_check_row (w_check_row),
         .i_horz      (r_active[r_dsp_idx[s]].horz),
         .i_vert      (r_active[r_dsp_idx[s]].vert),
         .i_wide      (r_active[r_dsp_idx[s]].attr.wide),
         .i_hflip     (r_active[r_dsp_idx[s]].attr.hflip),
         .i_vflip     (r_active[r_dsp_idx[s]].attr.vflip),
         .o_hit       (w_hit[s]),
         .o_wide      (w_wide[s]),
         .o_col       (w_col[s]),
         .o_row       (w_row[s])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         motionSel  <= 1'b0;
         motionWide <= 1'b0;
         spriteID   <= '0;
         mob_row    <= '0;
         mob_col    <= '0;
      end else begin
         motionSel  <= 1'b0;
         motionWide <= 1'b0;
         spriteID   <= '0;
         mob_row    <= '0;
         mob_col    <= '0;
         // Descending walk so the lowest slot is the last (winning) assignment
         for (int s = SLOTS - 1; s >= 0; s--) begin
            if (w_hit[s]) begin
               motionSel  <= 1'b1;
               motionWide <= w_wide[s];
               spriteID   <= r_active[r_dsp_idx[s]].picture;
               mob_row    <= w_row[s];
               mob_col    <= w_col[s];
            end
         end
      end
   end

`ifdef MOB_COLLIDE_EN
   logic [15:0] r_collide;

   always_ff @(posedge clk) begin
      if (rst || w_vb_rise) begin
         r_collide <= '0;
      end else if ($countones(w_hit) >= 2) begin
         for (int s = 0; s < SLOTS; s++)
            if (w_hit[s]) r_collide[4'(r_dsp_idx[s])] <= 1'b1;
      end
   end

   assign w_collide_bit = r_collide[bus.addr[3:0]];
`else
   assign w_collide_bit = 1'b0;
`endif

   assign bus.data_out = (bus.addr[15:4] == (BASE_ADDR[15:4] + 12'd3))
                         ? {overflow, 6'b0, w_collide_bit} : 8'h00;
endmodule
`default_nettype wire

// File: tb/tb_mob_line_engine.sv
`default_nettype none
// ============================================================================
// Module : tb_mob_line_engine
// Brief  : Directed self-checking bench for mob_line_engine.
// Rev    : 1.0  initial release
// ============================================================================
module tb_mob_line_engine;
`ifdef MOB_COLLIDE_EN
   localparam logic [7:0] C_COL = 8'h01;
`else
   localparam logic [7:0] C_COL = 8'h00;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] row;
   logic [7:0] col;
   logic       line_start;
   logic       vblank;
   logic       motionSel;
   logic       motionWide;
   logic [7:0] spriteID;
   logic [2:0] mob_row;
   logic [2:0] mob_col;
   logic       overflow;
   int         n_checks = 0;
   int         n_err    = 0;

   mob_line_engine_if bus ();

   mob_line_engine dut (
      .clk        (clk),
      .rst        (rst),
      .row        (row),
      .col        (col),
      .line_start (line_start),
      .vblank     (vblank),
      .bus        (bus),
      .motionSel  (motionSel),
      .motionWide (motionWide),
      .spriteID   (spriteID),
      .mob_row    (mob_row),
      .mob_col    (mob_col),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic wr(input logic [15:0] a, input logic [7:0] d);
      bus.addr = a; bus.data_in = d; bus.we_l = 1'b0;
      tick();
      bus.we_l = 1'b1;
   endtask

   task automatic wr_obj(input int i, input logic [7:0] pic, input logic [7:0] v,
                         input logic [7:0] h, input logic [7:0] at);
      wr(16'h07C0 + 16'(i), pic);
      wr(16'h07D0 + 16'(i), v);
      wr(16'h07E0 + 16'(i), h);
      wr(16'h07F0 + 16'(i), at);
   endtask

   task automatic pulse_vblank();
      vblank = 1'b1;
      tick(); tick();
      vblank = 1'b0;
      tick();
   endtask

   task automatic scan(input logic [7:0] r);
      row = r; line_start = 1'b1;
      tick();
      line_start = 1'b0;
      repeat (18) tick();
   endtask

   task automatic look(input string tag, input logic [7:0] c, input logic sel,
                       input logic wide, input logic [7:0] id,
                       input logic [2:0] r, input logic [2:0] cc);
      col = c;
      tick();
      chk({tag, ".sel"},  32'(motionSel),  32'(sel));
      chk({tag, ".wide"}, 32'(motionWide), 32'(wide));
      chk({tag, ".id"},   32'(spriteID),   32'(id));
      chk({tag, ".row"},  32'(mob_row),    32'(r));
      chk({tag, ".col"},  32'(mob_col),    32'(cc));
   endtask

   task automatic rd(input string tag, input logic [15:0] a, input logic [7:0] exp_v);
      bus.addr = a;
      #1;
      chk(tag, 32'(bus.data_out), 32'(exp_v));
   endtask

   initial begin
      rst = 1'b1; row = 8'd0; col = 8'd0; line_start = 1'b0; vblank = 1'b0;
      bus.addr = 16'h0000; bus.data_in = 8'h00; bus.we_l = 1'b1;
      tick(); tick();
      chk("rst.sel", 32'(motionSel), 32'd0);
      chk("rst.ovf", 32'(overflow), 32'd0);
      rd("rst.status", 16'h07F0, 8'h00);
      rst = 1'b0;
      tick();

      // Shadow only: nothing visible until the vblank copy
      wr_obj(0, 8'h01, 8'h0A, 8'h0A, 8'h00);
      scan(8'd229);
      look("shadow", 8'd10, 1'b0, 1'b0, 8'h00, 3'd0, 3'd0);
      pulse_vblank();
      scan(8'd229);
      look("basic", 8'd10, 1'b1, 1'b0, 8'h01, 3'd0, 3'd0);
      look("left",  8'd9,  1'b0, 1'b0, 8'h00, 3'd0, 3'd0);
      look("right", 8'd17, 1'b1, 1'b0, 8'h01, 3'd0, 3'd7);
      look("past",  8'd18, 1'b0, 1'b0, 8'h00, 3'd0, 3'd0);
      scan(8'd238);
      look("narrow_clip", 8'd10, 1'b0, 1'b0, 8'h00, 3'd0, 3'd0);

      wr(16'h07F0, 8'h01);
      pulse_vblank();
      scan(8'd236);
      look("wide7", 8'd10, 1'b1, 1'b0, 8'h01, 3'd7, 3'd0);
      scan(8'd238);
      look("wide9", 8'd10, 1'b1, 1'b1, 8'h01, 3'd1, 3'd0);

      wr(16'h07F0, 8'h06);
      pulse_vblank();
      scan(8'd229);
      look("flip", 8'd10, 1'b1, 1'b0, 8'h01, 3'd7, 3'd7);

      for (int i = 0; i < 10; i++)
         wr_obj(i, 8'(i + 1), 8'h0A, 8'(8 * i), 8'h00);
      pulse_vblank();
      scan(8'd229);
      for (int i = 0; i < 10; i++)
         look($sformatf("ten%0d", i), 8'(8 * i), (i < 8), 1'b0,
              (i < 8) ? 8'(i + 1) : 8'h00, 3'd0, 3'd0);
      chk("ovf.set", 32'(overflow), 32'd1);
      rd("ovf.read", 16'h07F0, 8'h80);
      rd("other.read", 16'h07E0, 8'h00);
      pulse_vblank();
      chk("ovf.clear", 32'(overflow), 32'd0);

      wr(16'h07E5, 8'd16);
      pulse_vblank();
      scan(8'd229);
      look("overlap", 8'd16, 1'b1, 1'b0, 8'h03, 3'd0, 3'd0);
      rd("coll2", 16'h07F2, 8'h80 | C_COL);
      rd("coll5", 16'h07F5, 8'h80 | C_COL);
      rd("coll3", 16'h07F3, 8'h80);

      row = 8'd229; line_start = 1'b1;
      tick();
      line_start = 1'b0;
      tick(); tick();
      rst = 1'b1;
      tick();
      chk("mid.sel", 32'(motionSel), 32'd0);
      chk("mid.id",  32'(spriteID),  32'd0);
      chk("mid.ovf", 32'(overflow),  32'd0);
      rd("mid.status", 16'h07F2, 8'h00);
      rst = 1'b0;
      tick();
      scan(8'd229);
      look("empty16", 8'd16, 1'b0, 1'b0, 8'h00, 3'd0, 3'd0);
      look("empty0",  8'd0,  1'b0, 1'b0, 8'h00, 3'd0, 3'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
`default_nettype wire
